// File: rtl/mult_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_unit_if : request/response bundle of the EX-stage multiplier    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mult_unit_if #(
   parameter int DATA_W = 64
);
   logic              start;
   logic [2:0]        func3;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic [4:0]        rd_in;
   logic              stall;
   logic              result_valid;
   logic [DATA_W-1:0] result;
   logic [4:0]        rd_out;

   modport master (
      output start, func3, operand_a, operand_b, rd_in,
      input  stall, result_valid, result, rd_out
   );

   modport slave (
      input  start, func3, operand_a, operand_b, rd_in,
      output stall, result_valid, result, rd_out
   );
endinterface
`default_nettype wire

// File: rtl/mult_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_unit : radix-2 shift-add RV64M multiplier (MUL/MULH/MULHSU/MULHU)|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mult_unit #(
   parameter int DATA_W = 64
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        enable,
   input  logic        flush,
   mult_unit_if.slave  bus
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [CNT_W-1:0]    counter;
   logic [DATA_W-1:0]   mcand;
   logic [2*DATA_W-1:0] product;
   logic                neg;
   logic [2:0]          op;
   logic [4:0]          rd_lat;
   logic [DATA_W-1:0]   result_q;
   logic [4:0]          rd_out_q;

   logic                signed_a, signed_b, a_neg, b_neg;
   logic [DATA_W-1:0]   abs_a, abs_b;
   logic [DATA_W:0]     sum;
   logic [2*DATA_W-1:0] shifted, fixed;
   logic [DATA_W-1:0]   selected;
   logic                stall_c, valid_c;

   // Operand signedness; func3 1xx falls through to the MULHU (unsigned) path.
   always_comb begin
      signed_a = (bus.func3 == 3'b001) || (bus.func3 == 3'b010);
      signed_b = (bus.func3 == 3'b001);
      a_neg    = signed_a & bus.operand_a[DATA_W-1];
      b_neg    = signed_b & bus.operand_b[DATA_W-1];
      abs_a    = a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
      abs_b    = b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;
   end

   always_comb begin
      sum      = {1'b0, product[2*DATA_W-1:DATA_W]}
               + (product[0] ? {1'b0, mcand} : {(DATA_W+1){1'b0}});
      shifted  = {sum, product[DATA_W-1:1]};
      fixed    = neg ? (~product + 1'b1) : product;
      selected = (op == 3'b000) ? fixed[DATA_W-1:0] : fixed[2*DATA_W-1:DATA_W];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      stall_c  = 1'b0;
      valid_c  = 1'b0;
      case (state)
         S_IDLE:  stall_c = bus.start & ~flush;
         S_BUSY:  stall_c = 1'b1;
         S_FIX:   stall_c = 1'b1;
         S_DONE:  valid_c = 1'b1;
         default: stall_c = 1'b0;
      endcase
      if (enable) begin
         if (flush) begin
            state_nx = S_IDLE;
         end else begin
            case (state)
               S_IDLE:  if (bus.start) state_nx = S_BUSY;
               S_BUSY:  if (counter == LAST_CNT) state_nx = S_FIX;
               S_FIX:   state_nx = S_DONE;
               S_DONE:  state_nx = S_IDLE;
               default: state_nx = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         counter  <= '0;
         mcand    <= '0;
         product  <= '0;
         neg      <= 1'b0;
         op       <= 3'b000;
         rd_lat   <= 5'd0;
         result_q <= '0;
         rd_out_q <= 5'd0;
      end else if (enable && !flush) begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  mcand   <= abs_a;
                  product <= {{DATA_W{1'b0}}, abs_b};
                  counter <= '0;
                  neg     <= a_neg ^ b_neg;
                  op      <= bus.func3;
                  rd_lat  <= bus.rd_in;
               end
            end
            S_BUSY: begin
               product <= shifted;
               counter <= counter + CNT_W'(1);
            end
            // Outputs are captured here so they are already stable throughout DONE.
            S_FIX: begin
               product  <= fixed;
               result_q <= selected;
               rd_out_q <= rd_lat;
            end
            default: begin
               counter <= counter;
            end
         endcase
      end
   end

   assign bus.stall        = stall_c;
   assign bus.result_valid = valid_c;
   assign bus.result       = result_q;
   assign bus.rd_out       = rd_out_q;
endmodule
`default_nettype wire
